// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 16x oversampling factor and baud divisor table.
// Pure constants and elaboration-time helpers; no timing or flow-control behaviour of its own.
package uart_pkg;

   localparam int unsigned OVERSAMPLE     = 16;
   localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam int unsigned BAUD_TABLE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
   localparam int unsigned DIV_TABLE  [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

   // The table is exact for the default clock; other clocks get the nearest rounded divisor.
   function automatic int unsigned baud_div(input logic [2:0] code, input int unsigned clk_hz);
      if (clk_hz == DEFAULT_CLK_HZ)
         return DIV_TABLE[code];
      return (clk_hz + (OVERSAMPLE * BAUD_TABLE[code]) / 2) / (OVERSAMPLE * BAUD_TABLE[code]);
   endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// 16x-baud tick generator: one-clk sample_ENABLE every DIV clocks; restart clears the divider.
// Tick is combinational from the counter; no backpressure, free-running between restarts.
module baud_controller
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       sample_ENABLE
);

   localparam int unsigned CW = $clog2(baud_div(3'd0, CLK_HZ) + 1);

   localparam logic [CW-1:0] DIV_M1 [8] = '{
      CW'(baud_div(3'd0, CLK_HZ) - 1), CW'(baud_div(3'd1, CLK_HZ) - 1),
      CW'(baud_div(3'd2, CLK_HZ) - 1), CW'(baud_div(3'd3, CLK_HZ) - 1),
      CW'(baud_div(3'd4, CLK_HZ) - 1), CW'(baud_div(3'd5, CLK_HZ) - 1),
      CW'(baud_div(3'd6, CLK_HZ) - 1), CW'(baud_div(3'd7, CLK_HZ) - 1)
   };

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap          = (cnt == DIV_M1[baud_select]);
   assign sample_ENABLE = !restart && wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (restart || wrap)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter (8E1 when UART_TX_PARITY_EN is defined); TxD/Tx_BUSY change one clk after an accepted write.
// Writes while busy or disabled are dropped (no queueing); the driver must wait for Tx_BUSY low.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   input  logic [2:0] baud_select,
   output logic       TxD,
   output logic       Tx_BUSY
);

   logic [2:0] state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] data_q;
   logic [2:0] baud_q;
`ifdef UART_TX_PARITY_EN
   logic       parity_q;
`endif
   logic       accept;
   logic       tick;
   logic       bit_end;

   assign accept  = Tx_WR && Tx_EN && !Tx_BUSY;
   assign bit_end = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

   // Restarting on accept makes the start bit a full 16*DIV clocks regardless of divider phase.
   baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
      .clk           (clk),
      .reset         (reset),
      .baud_select   (baud_q),
      .restart       (accept),
      .sample_ENABLE (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         TxD      <= 1'b1;
         Tx_BUSY  <= 1'b0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         data_q   <= '0;
         baud_q   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         if (state != IDLE && tick)
            tick_cnt <= tick_cnt + 4'd1;
         case (state)
            IDLE: if (accept) begin
               state    <= START;
               TxD      <= 1'b0;
               Tx_BUSY  <= 1'b1;
               data_q   <= Tx_DATA;
               baud_q   <= baud_select;
               tick_cnt <= '0;
               bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
               parity_q <= ^Tx_DATA;
`endif
            end
            START: if (bit_end) begin
               state <= DATA;
               TxD   <= data_q[0];
            end
            DATA: if (bit_end) begin
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state <= PARITY;
                  TxD   <= parity_q;
`else
                  state <= STOP;
                  TxD   <= 1'b1;
`endif
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  data_q  <= {1'b0, data_q[7:1]};
                  TxD     <= data_q[1];
               end
            end
            PARITY: if (bit_end) begin
               state <= STOP;
               TxD   <= 1'b1;
            end
            STOP: if (bit_end) begin
               state   <= IDLE;
               Tx_BUSY <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               TxD     <= 1'b1;
               Tx_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency (divisor table in REQ-011 is for this default).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port Tx_EN  input  1  transmitter enable.
REQ-005 SHALL have port Tx_WR  input  1  one-cycle write strobe from driver.
REQ-006 SHALL have port Tx_DATA  input  8  byte to send, sampled with Tx_WR.
REQ-007 SHALL have port baud_select  input  3  baud rate code.
REQ-008 SHALL have port TxD  output  1  serial line, idle high.
REQ-009 SHALL have port Tx_BUSY  output  1  high while a frame is in progress.

Function
REQ-010 SHALL generate a sample tick at 16x baud: a one-clk pulse every DIV clocks, where DIV comes from baud_select.
REQ-011 SHALL map baud_select 0..7 to baud 300/1200/4800/9600/19200/38400/57600/115200, with DIV 10417/2604/651/326/163/81/54/27.
REQ-012 SHALL accept a write when Tx_WR=1, Tx_EN=1 and Tx_BUSY=0 at a clk edge, latching Tx_DATA and baud_select.
- Tx_WR while Tx_BUSY=1 or Tx_EN=0: ignored, no state change.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after 16 ticks.
- DATA -> PARITY (macro on) or STOP after 8 bits x 16 ticks.
- PARITY -> STOP after 16 ticks.
- STOP -> IDLE after 16 ticks.
REQ-014 SHALL drive TxD=0 in START, data LSB first in DATA, parity in PARITY, and 1 in STOP and IDLE; each bit lasts exactly 16 ticks (16*DIV clocks).
REQ-015 SHALL restart the tick divider at accept so the start bit is exactly 16*DIV clocks long.
REQ-016 SHALL raise Tx_BUSY and drive TxD low on the clk edge after accept (one-cycle latency).
REQ-017 SHALL drop Tx_BUSY on the same edge it returns to IDLE; a Tx_WR on the next cycle is accepted (back-to-back frames with no idle gap beyond one clk).
REQ-018 SHALL ignore changes to Tx_DATA and baud_select during a frame.
REQ-019 SHALL finish a frame already in progress when Tx_EN falls mid-frame; new writes are refused afterwards.

Reset
REQ-020 SHALL on reset low, asynchronously and immediately: state=IDLE, TxD=1, Tx_BUSY=0, divider and bit counters=0, data register=0.
REQ-021 SHALL, when reset is asserted mid-frame, abort the frame at once with TxD=1; no partial-frame resume after release.

Configuration
REQ-022 SHALL, with UART_TX_PARITY_EN defined, send an even-parity bit (XOR of the 8 data bits) after the data, giving an 11-bit frame.
REQ-023 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, giving a 10-bit 8N1 frame.

Structure
REQ-024 SHALL place FSM state encoding, the divisor table constants and OVERSAMPLE=16 in shared package uart_pkg, also used by the receiver.
REQ-025 SHALL implement the tick generator as sub-module baud_controller (inputs clk, reset, baud_select, restart; output sample_ENABLE).

Verification
REQ-026 SHALL cover: baud_select=7, Tx_EN=1, Tx_WR with 0xA5, parity off -> TxD bits 0,1,0,1,0,0,1,0,1,1, each 432 clk; Tx_BUSY high for 4320 clk.
REQ-027 SHALL cover: parity on, 0x07 -> parity bit 1, frame 4752 clk at baud_select=7; with 0x03 -> parity bit 0.
REQ-028 SHALL cover: Tx_WR with 0x55 during a frame of 0xAA -> only 0xAA transmitted; 0x55 is not sent.
REQ-029 SHALL cover: Tx_WR the cycle after Tx_BUSY falls -> second frame's start bit begins 1 clk after first stop bit ends.
REQ-030 SHALL cover: reset low at the 4th data bit -> TxD=1 and Tx_BUSY=0 asynchronously; after release the line stays idle until a new Tx_WR.
REQ-031 SHALL cover: Tx_EN=0 with Tx_WR -> TxD stays 1; Tx_EN dropped mid-frame -> frame completes with all 10 bits.
